uart_cmd_sender: RTL and testbench

- Host-side initiator for the node command protocol: serialises one 6-byte command frame onto a UART 8N1 line.
- Frame bytes: node address, opcode, then 32-bit payload least-significant byte first.
- Drives the `host_tx` input of a node such as the perceptron. Enables on-chip hosts and bus-functional models to stream commands without a PC.
- Built-in inter-byte idle gap matches the node's byte-parsing turnaround.

---
 rtl/uart_cmd_sender.sv | 154 +++++++++++++++
 tb/tb_uart_cmd_sender.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sender.sv
// Host-side command initiator: serialises {addr, op, data[7:0..31:24]} as six
// UART 8N1 bytes, each followed by an idle-high gap, then pulses done.
module uart_cmd_sender #(
  parameter int CLKS_PER_BIT = 430,
  parameter int GAP_CLKS     = 4500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    idx_q, idx_d;
  logic [47:0]   shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_last;
  logic          byte_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    gap_d     = gap_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    byte_end  = 1'b0;
    baud_last = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          shreg_d = {cmd_data, cmd_op, cmd_addr};
          idx_d   = '0;
          baud_d  = '0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          gap_d  = '0;
          if (GAP_CLKS == 0) begin
            byte_end = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          byte_end = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The last byte's gap ends the frame; earlier gaps roll into the next start bit.
    if (byte_end) begin
      if (idx_q == 3'd5) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d   = idx_q + 3'd1;
        shreg_d = shreg_q >> 8;
        state_d = S_START;
      end
    end

    // Line level follows the state being entered, so uart_tx is a plain flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign uart_tx   = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Bench for uart_cmd_sender: three instances (4/8, 4/0 and default timing), each
// with a timing model feeding a byte scoreboard that a receiving BFM drains.
module tb_uart_cmd_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic end_req = 1'b0;

  logic [2:0]  rst_v, valid_v, tx_v, ready_v, busy_v, done_v;
  logic [7:0]  addr_v [3];
  logic [7:0]  op_v   [3];
  logic [31:0] data_v [3];

  typedef struct {
    logic [7:0] val;
    int         start;
  } exp_byte_t;

  task automatic chk(input string name, input int id, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", name, id, cyc, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int C       = (gi == 2) ? 430 : 4;
    localparam int G       = (gi == 0) ? 8 : ((gi == 1) ? 0 : 4500);
    localparam int BYTE_T  = 10 * C + G;
    localparam int FRAME_T = 6 * BYTE_T;

    if (gi == 2) begin : g_def
      uart_cmd_sender u_dut (
        .clk(clk), .rst(rst_v[gi]), .cmd_valid(valid_v[gi]), .cmd_ready(ready_v[gi]),
        .cmd_addr(addr_v[gi]), .cmd_op(op_v[gi]), .cmd_data(data_v[gi]),
        .uart_tx(tx_v[gi]), .busy(busy_v[gi]), .done(done_v[gi])
      );
    end else begin : g_par
      uart_cmd_sender #(.CLKS_PER_BIT(C), .GAP_CLKS(G)) u_dut (
        .clk(clk), .rst(rst_v[gi]), .cmd_valid(valid_v[gi]), .cmd_ready(ready_v[gi]),
        .cmd_addr(addr_v[gi]), .cmd_op(op_v[gi]), .cmd_data(data_v[gi]),
        .uart_tx(tx_v[gi]), .busy(busy_v[gi]), .done(done_v[gi])
      );
    end

    exp_byte_t bq[$];
    int        dq[$];
    int        busy_from  = 0;
    int        busy_until = 0;

    // Timing model: a frame accepted at the edge after sample cycle c is busy
    // for FRAME_T cycles, byte j starts at c+1+j*BYTE_T, done lands at the end.
    always @(negedge clk) begin : model
      logic       exp_busy;
      logic       exp_done;
      logic [7:0] b [6];
      exp_byte_t  e;
      exp_busy = (cyc >= busy_from) && (cyc < busy_until);
      exp_done = (dq.size() > 0) && (dq[0] == cyc);
      chk("busy", gi, 48'(busy_v[gi]), 48'(exp_busy));
      chk("cmd_ready", gi, 48'(ready_v[gi]), 48'(!exp_busy));
      chk("done", gi, 48'(done_v[gi]), 48'(exp_done));
      if (!exp_busy) chk("idle_line", gi, 48'(tx_v[gi]), 48'd1);
      if (exp_done) void'(dq.pop_front());
      if (rst_v[gi]) begin
        busy_from  = 0;
        busy_until = 0;
        bq.delete();
        dq.delete();
      end else if (valid_v[gi] && !exp_busy) begin
        busy_from  = cyc + 1;
        busy_until = cyc + 1 + FRAME_T;
        dq.push_back(busy_until);
        b[0] = addr_v[gi];
        b[1] = op_v[gi];
        for (int j = 0; j < 4; j++) b[2 + j] = 8'(data_v[gi] >> (8 * j));
        for (int j = 0; j < 6; j++) begin
          e.val   = b[j];
          e.start = cyc + 1 + j * BYTE_T;
          bq.push_back(e);
        end
      end
    end

    // Receiving BFM: decodes at bit centres and checks start/stop/gap levels.
    initial begin : rx
      exp_byte_t  e;
      logic [7:0] v;
      logic       shape_ok, aborted, have_exp;
      int         s;
      forever begin
        @(negedge clk);
        if (!rst_v[gi] && tx_v[gi] === 1'b0) begin
          s        = cyc;
          v        = '0;
          shape_ok = 1'b1;
          aborted  = 1'b0;
          have_exp = (bq.size() > 0);
          if (have_exp) begin
            e = bq.pop_front();
            chk("start_cycle", gi, 48'(s), 48'(e.start));
          end else begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected_start dut%0d cyc=%0d got=start_bit expected=idle", gi, s);
          end
          for (int t = 1; t < BYTE_T && !aborted; t++) begin
            @(negedge clk);
            if (rst_v[gi]) aborted = 1'b1;
            else if (t < C) shape_ok = shape_ok & (tx_v[gi] === 1'b0);
            else if (t < 9 * C) begin
              if ((t % C) == C / 2) v[3'((t - C) / C)] = tx_v[gi];
            end else shape_ok = shape_ok & (tx_v[gi] === 1'b1);
          end
          if (have_exp && !aborted) begin
            chk("byte_value", gi, 48'(v), 48'(e.val));
            chk("start_stop_gap_level", gi, 48'(shape_ok), 48'd1);
          end
        end
      end
    end

    initial begin : drain
      wait (end_req);
      chk("bytes_pending", gi, 48'(bq.size()), 48'd0);
      chk("done_pending", gi, 48'(dq.size()), 48'd0);
    end
  end

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] op,
                      input logic [31:0] d, input bit keep);
    int n;
    addr_v[i]  = a;
    op_v[i]    = op;
    data_v[i]  = d;
    valid_v[i] = 1'b1;
    n = 0;
    @(negedge clk);
    while (ready_v[i] !== 1'b1 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d got=no_ready expected=ready", i);
    end
    @(posedge clk);
    #1;
    if (!keep) begin
      valid_v[i] = 1'b0;
      addr_v[i]  = 8'($urandom());
      op_v[i]    = 8'($urandom());
      data_v[i]  = $urandom();
    end
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (done_v[i] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d got=no_done expected=done", i);
    end
    @(posedge clk);
    #1;
  endtask

  // Requests presented while the frame is in flight must be ignored.
  task automatic garbage_busy(input int i, input int n);
    valid_v[i] = 1'b1;
    repeat (n) begin
      addr_v[i] = 8'($urandom());
      op_v[i]   = 8'($urandom());
      data_v[i] = $urandom();
      @(posedge clk);
      #1;
    end
    valid_v[i] = 1'b0;
  endtask

  initial begin
    rst_v   = 3'b111;
    valid_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0;
      op_v[i]   = '0;
      data_v[i] = '0;
    end
    repeat (5) @(posedge clk);
    #1;
    rst_v = 3'b000;

    fork
      begin : thread_a
        repeat (1000) @(posedge clk);
        #1;
        send(0, 8'd100, 8'd0, 32'h0000_0001, 1'b0);
        garbage_busy(0, 100);
        wait_done(0, 400);
        send(0, 8'd101, 8'd6, 32'hA1B2_C3D4, 1'b0);
        wait_done(0, 400);
        send(0, 8'd101, 8'd1, 32'h1122_3344, 1'b1);
        send(0, 8'd100, 8'd2, 32'h5566_7788, 1'b0);
        wait_done(0, 400);
        // Byte 3 is 0x00, so the line is low when reset lands in its data bits.
        send(0, 8'd100, 8'd3, 32'h5A5A_0055, 1'b0);
        repeat (160) @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        send(0, 8'd100, 8'd9, 32'hCAFE_F00D, 1'b0);
        wait_done(0, 400);
        for (int k = 0; k < 4; k++) begin
          send(0, 8'($urandom()), 8'($urandom()), $urandom(), k == 1);
          if (k != 1) begin
            garbage_busy(0, $urandom_range(1, 100));
            wait_done(0, 400);
          end
        end
      end
      begin : thread_b
        send(1, 8'($urandom()), 8'($urandom()), $urandom(), 1'b1);
        send(1, 8'($urandom()), 8'($urandom()), $urandom(), 1'b0);
        wait_done(1, 400);
        send(1, 8'($urandom()), 8'($urandom()), $urandom(), 1'b0);
        garbage_busy(1, 50);
        wait_done(1, 400);
      end
      begin : thread_d
        send(2, 8'd100, 8'd5, 32'h0BAD_BEEF, 1'b0);
        wait_done(2, 60000);
      end
    join

    repeat (5) @(posedge clk);
    end_req = 1'b1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
